// File: rtl/riscboy_ppu_pmap_stream.sv
// Streaming palette mapper: forms palette indices from 8/4/2-bit pixels, reads a
// synchronous palette RAM, and buffers results in a credit-controlled output FIFO.
module riscboy_ppu_pmap_stream #(
  parameter int W_PIXDATA     = 16,
  parameter int W_PALETTE_IDX = 8,
  parameter int OUT_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [W_PIXDATA-1:0]     in_data,
  input  logic [1:0]               in_mode,
  input  logic [W_PALETTE_IDX-1:0] in_pal_base,
  input  logic                     in_transp_en,
  input  logic [W_PALETTE_IDX-1:0] pram_waddr,
  input  logic [W_PIXDATA-1:0]     pram_wdata,
  input  logic                     pram_wen,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [W_PIXDATA-1:0]     out_data,
  output logic                     out_transp
);

  localparam int PDEPTH = 1 << W_PALETTE_IDX;
  localparam int PW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW     = $clog2(OUT_DEPTH + 1) + 1;

  logic [W_PALETTE_IDX-1:0] mask_s, idx_s;
  logic                     accept_s, direct_s, transp_s, ren_s, hit_s;

  logic [W_PIXDATA-1:0]     pram_mem [PDEPTH];
  logic [W_PIXDATA-1:0]     pram_rdata_d, pram_rdata_q;

  logic                     p_vld_d, p_vld_q;
  logic                     p_direct_d, p_direct_q;
  logic                     p_transp_d, p_transp_q;
  logic                     p_hit_d, p_hit_q;
  logic [W_PIXDATA-1:0]     p_data_d, p_data_q;
  logic [W_PIXDATA-1:0]     p_wdata_d, p_wdata_q;

  logic [W_PIXDATA-1:0]     fifo_colour_q [OUT_DEPTH];
  logic                     fifo_transp_q [OUT_DEPTH];
  logic [PW-1:0]            wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CW-1:0]            count_d, count_q;
  logic                     push_s, pop_s;
  logic [W_PIXDATA-1:0]     push_colour_s;

  // Index formation, transparency and palette-read request for the input pixel
  always_comb begin
    case (in_mode)
      2'd2:    mask_s = {{(W_PALETTE_IDX-4){1'b0}}, 4'hf};
      2'd3:    mask_s = {{(W_PALETTE_IDX-2){1'b0}}, 2'b11};
      default: mask_s = {W_PALETTE_IDX{1'b1}};
    endcase
    accept_s = in_vld && in_rdy;
    direct_s = (in_mode == 2'd0);
    idx_s    = (in_pal_base & ~mask_s) | (in_data[W_PALETTE_IDX-1:0] & mask_s);
    transp_s = in_transp_en && !direct_s &&
               ((in_data[W_PALETTE_IDX-1:0] & mask_s) == {W_PALETTE_IDX{1'b0}});
    ren_s    = accept_s && !direct_s;
    // A same-cycle write to the index being read must win over the stale RAM word
    hit_s    = ren_s && pram_wen && (pram_waddr == idx_s);
  end

  // Palette RAM write port
  always_ff @(posedge clk) begin
    if (pram_wen) begin
      pram_mem[pram_waddr] <= pram_wdata;
    end
  end

  // Stage P next state, FIFO push/pop and pointer/count updates
  always_comb begin
    pram_rdata_d = ren_s ? pram_mem[idx_s] : pram_rdata_q;
    p_vld_d      = accept_s;
    if (accept_s) begin
      p_direct_d = direct_s;
      p_transp_d = transp_s;
      p_hit_d    = hit_s;
      p_data_d   = in_data;
      p_wdata_d  = pram_wdata;
    end else begin
      p_direct_d = p_direct_q;
      p_transp_d = p_transp_q;
      p_hit_d    = p_hit_q;
      p_data_d   = p_data_q;
      p_wdata_d  = p_wdata_q;
    end

    push_s        = p_vld_q;
    pop_s         = out_vld && out_rdy;
    push_colour_s = p_direct_q ? p_data_q : (p_hit_q ? p_wdata_q : pram_rdata_q);

    if (push_s) begin
      wptr_d = (wptr_q == PW'(OUT_DEPTH - 1)) ? {PW{1'b0}} : wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == PW'(OUT_DEPTH - 1)) ? {PW{1'b0}} : rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output handshake; in_rdy counts the pixel in stage P as a spent credit
  always_comb begin
    in_rdy     = (count_q + CW'(p_vld_q)) < CW'(OUT_DEPTH);
    out_vld    = (count_q != {CW{1'b0}});
    out_data   = fifo_colour_q[rptr_q];
    out_transp = out_vld && fifo_transp_q[rptr_q];
  end

  // Control and stage-P state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pram_rdata_q <= {W_PIXDATA{1'b0}};
      p_vld_q      <= 1'b0;
      p_direct_q   <= 1'b0;
      p_transp_q   <= 1'b0;
      p_hit_q      <= 1'b0;
      p_data_q     <= {W_PIXDATA{1'b0}};
      p_wdata_q    <= {W_PIXDATA{1'b0}};
      wptr_q       <= {PW{1'b0}};
      rptr_q       <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
    end else begin
      pram_rdata_q <= pram_rdata_d;
      p_vld_q      <= p_vld_d;
      p_direct_q   <= p_direct_d;
      p_transp_q   <= p_transp_d;
      p_hit_q      <= p_hit_d;
      p_data_q     <= p_data_d;
      p_wdata_q    <= p_wdata_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful under the count
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_colour_q[wptr_q] <= push_colour_s;
      fifo_transp_q[wptr_q] <= p_transp_q;
    end
  end

endmodule
